// File: rtl/ro_edge_counter.sv
// Counts rising edges of a PUF ring oscillator while a synchronized enable is high,
// publishing binary, registered Gray code and a sticky saturation flag in the count_clk domain.
module ro_edge_counter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             count_clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count_bin,
    output logic [WIDTH-1:0] count_gray,
    output logic             saturated,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   en_s;
    state_t                 state;
    logic [WIDTH-1:0]       bin_next;
    logic [WIDTH-1:0]       gray_next;

    // en is asynchronous to the oscillator; only the last stage feeds the FSM
    always_ff @(posedge count_clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], en};
        end
    end

    assign en_s = sync_q[SYNC_STAGES-1];

    // Saturating increment: the counter never wraps, so the Gray code never jumps
    always_comb begin
        bin_next  = (count_bin == ALL_ONES) ? count_bin : count_bin + ONE;
        gray_next = bin_next ^ (bin_next >> 1);
    end

    always_ff @(posedge count_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count_bin  <= '0;
            count_gray <= '0;
            saturated  <= 1'b0;
            running    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_s) begin
                        state      <= COUNT;
                        running    <= 1'b1;
                        count_bin  <= bin_next;
                        count_gray <= gray_next;
                        saturated  <= saturated | (bin_next == ALL_ONES);
                    end
                end
                COUNT: begin
                    if (en_s) begin
                        count_bin  <= bin_next;
                        count_gray <= gray_next;
                        saturated  <= saturated | (bin_next == ALL_ONES);
                    end else begin
                        state   <= HOLD;
                        running <= 1'b0;
                    end
                end
                HOLD: begin
                    // Frozen until reset; a late re-assert of en must not extend the measurement
                    state   <= HOLD;
                    running <= 1'b0;
                end
                default: begin
                    state   <= HOLD;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
